// File: rtl/bus_window_array.sv
// rtl/bus_window_array.sv - register bus splitter into NWIN address windows with tracked, timed-out reads
module bus_window_array #(
    parameter int NWIN       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NWIN*ADDR_WIDTH-1:0] BASE_ADDRS = '0,
    parameter logic [NWIN*8-1:0]          WIN_BITS   = {NWIN{8'd8}},
    parameter int TIMEOUT    = 64,
    parameter logic [DATA_WIDTH-1:0]      ERR_DATA   = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                         bus_clk,
    input  logic                         bus_reset,
    input  logic                         bus_rd_req,
    input  logic                         bus_wr_req,
    input  logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic [DATA_WIDTH-1:0]        bus_wr_data,
    input  logic [3:0]                   bus_be,
    output logic [DATA_WIDTH-1:0]        bus_rd_data,
    output logic                         bus_rd_ack,
    output logic                         bus_err,
    output logic [NWIN-1:0]              sub_rd_req,
    output logic [NWIN-1:0]              sub_wr_req,
    output logic [NWIN*ADDR_WIDTH-1:0]   sub_addr,
    output logic [DATA_WIDTH-1:0]        sub_wr_data,
    output logic [3:0]                   sub_be,
    input  logic [NWIN*DATA_WIDTH-1:0]   sub_rd_data,
    input  logic [NWIN-1:0]              sub_rd_ack
);
    localparam int IW = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t                  state;
    logic [IW-1:0]           pend;
    logic [CW-1:0]           cnt;

    logic [ADDR_WIDTH-1:0]   win_mask [NWIN];
    logic [ADDR_WIDTH-1:0]   win_base [NWIN];
    logic [DATA_WIDTH-1:0]   rd_word  [NWIN];
    logic [NWIN-1:0]         raw_hit;
    logic [NWIN-1:0]         hit;
    logic [IW-1:0]           hit_idx;
    logic                    found;

    // win_mask selects the address bits above the window, which must match the base
    for (genvar g = 0; g < NWIN; g++) begin : g_dec
        assign win_mask[g] = {ADDR_WIDTH{1'b1}} << WIN_BITS[g*8 +: 8];
        assign win_base[g] = BASE_ADDRS[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_word[g]  = sub_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign raw_hit[g]  = ((bus_addr ^ win_base[g]) & win_mask[g]) == '0;
    end

    // Overlapping windows resolve to the lowest index
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NWIN; i++) begin
            if (raw_hit[i] && !found) begin
                hit[i]  = 1'b1;
                hit_idx = IW'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state       <= IDLE;
            pend        <= '0;
            cnt         <= '0;
            bus_rd_data <= '0;
            bus_rd_ack  <= 1'b0;
            bus_err     <= 1'b0;
            sub_rd_req  <= '0;
            sub_wr_req  <= '0;
            sub_addr    <= '0;
            sub_wr_data <= '0;
            sub_be      <= '0;
        end else begin
            sub_rd_req  <= '0;
            sub_wr_req  <= bus_wr_req ? hit : '0;
            sub_wr_data <= bus_wr_data;
            sub_be      <= bus_be;
            for (int i = 0; i < NWIN; i++) begin
                sub_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <=
                    (win_base[i] & win_mask[i]) | (bus_addr & ~win_mask[i]);
            end
            bus_rd_ack <= 1'b0;
            // A read that cannot be tracked is refused with a bare error pulse
            bus_err    <= bus_rd_req && (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus_rd_req) begin
                        if (found) begin
                            sub_rd_req <= hit;
                            pend       <= hit_idx;
                            cnt        <= '0;
                            state      <= WAIT;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                WAIT: begin
                    if (sub_rd_ack[pend]) begin
                        bus_rd_ack  <= 1'b1;
                        bus_rd_data <= rd_word[pend];
                        state       <= IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus_rd_ack  <= 1'b1;
                        bus_rd_data <= ERR_DATA;
                        bus_err     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    bus_rd_ack  <= 1'b1;
                    bus_rd_data <= ERR_DATA;
                    bus_err     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
